latch_load_arbiter: RTL and testbench

//  Round-robin arbiter sharing one level-sensitive WIDTH-bit latch among NREQ

---
 rtl/latch_load_arbiter.sv | 112 +++++++++++
 tb/tb_latch_load_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/latch_load_arbiter.sv
// latch_load_arbiter: round-robin arbiter sharing one level-sensitive latch among NREQ requesters.
// Each transfer runs IDLE -> GRANT -> LOAD; every output comes straight from a register.
module latch_load_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rdy,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic                  load,
    output logic [WIDTH-1:0]      latch_in,
    output logic [NREQ-1:0]       ack,
    output logic                  busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [PW-1:0]     owner_q;
    logic [NREQ-1:0]   grant_q;
    logic              load_q;
    logic [WIDTH-1:0]  latch_in_q;
    logic [NREQ-1:0]   ack_q;
    logic              busy_q;
    logic              win_found;
    logic [PW-1:0]     win_idx;

    // Scan from ptr upwards with wrap; descending loop so the closest requester wins.
    always_comb begin : pick
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            j = (j >= NREQ) ? j - NREQ : j;
            if (req[PW'(j)]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    assign ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            load_q     <= 1'b0;
            latch_in_q <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdy && win_found) begin
                        grant_q <= NREQ'(1) << win_idx;
                        owner_q <= win_idx;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[owner_q]) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (rdy) begin
                        latch_in_q <= data_in[int'(owner_q)*WIDTH +: WIDTH];
                        load_q     <= 1'b1;
                        ack_q      <= grant_q;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    ack_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    load_q  <= 1'b0;
                    ack_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign load     = load_q;
    assign latch_in = latch_in_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_latch_load_arbiter.sv
// tb_latch_load_arbiter: directed vector table plus hand sequences for stall and reset-in-load.
module tb_latch_load_arbiter;
    logic        clk;
    logic        reset;
    logic        rdy;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic        load;
    logic [7:0]  latch_in;
    logic [3:0]  ack;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [3:0] req;
        logic [3:0] g;
        logic       ld;
        logic [7:0] li;
        logic [3:0] ak;
        logic       bz;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] dat[4];

    latch_load_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk(clk),
        .reset(reset),
        .rdy(rdy),
        .req(req),
        .data_in(data_in),
        .grant(grant),
        .load(load),
        .latch_in(latch_in),
        .ack(ack),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic ld,
                           input logic [7:0] li, input logic [3:0] ak, input logic bz);
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " load"}, 32'(load), 32'(ld));
        chk({tag, " latch_in"}, 32'(latch_in), 32'(li));
        chk({tag, " ack"}, 32'(ack), 32'(ak));
        chk({tag, " busy"}, 32'(busy), 32'(bz));
    endtask

    function automatic void add(input logic rs, input logic rd, input logic [3:0] rq,
                                input logic [3:0] g, input logic ld, input logic [7:0] li,
                                input logic [3:0] ak, input logic bz);
        vec_t v;
        v.rst = rs; v.rdy = rd; v.req = rq; v.g = g; v.ld = ld; v.li = li; v.ak = ak; v.bz = bz;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] lat;
        logic [3:0] oh;
        checks   = 0;
        failures = 0;
        dat      = '{8'h11, 8'h22, 8'hA5, 8'h44};
        data_in  = {dat[3], dat[2], dat[1], dat[0]};
        reset    = 1'b1;
        rdy      = 1'b1;
        req      = 4'b0000;
        // reset, then single transfer from requester 2
        add(1, 1, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 1, 4'b0100, 4'b0100, 0, 8'h00, 4'b0000, 1);
        add(0, 1, 4'b0100, 4'b0100, 1, 8'hA5, 4'b0100, 1);
        add(0, 1, 4'b0000, 4'b0000, 0, 8'hA5, 4'b0000, 0);
        // ptr=3, req 1001: owner 3 then wraps to 0
        add(0, 1, 4'b1001, 4'b1000, 0, 8'hA5, 4'b0000, 1);
        add(0, 1, 4'b1001, 4'b1000, 1, 8'h44, 4'b1000, 1);
        add(0, 1, 4'b1001, 4'b0000, 0, 8'h44, 4'b0000, 0);
        add(0, 1, 4'b1001, 4'b0001, 0, 8'h44, 4'b0000, 1);
        add(0, 1, 4'b1001, 4'b0001, 1, 8'h11, 4'b0001, 1);
        add(0, 1, 4'b1001, 4'b0000, 0, 8'h11, 4'b0000, 0);
        // all requesting after reset: order 0,1,2,3,0,1,2,3
        add(1, 1, 4'b1111, 4'b0000, 0, 8'h00, 4'b0000, 0);
        lat = 8'h00;
        for (int t = 0; t < 8; t++) begin
            oh = 4'b0001 << (t % 4);
            add(0, 1, 4'b1111, oh, 0, lat, 4'b0000, 1);
            add(0, 1, 4'b1111, oh, 1, dat[t%4], oh, 1);
            add(0, 1, 4'b1111, 4'b0000, 0, dat[t%4], 4'b0000, 0);
            lat = dat[t%4];
        end
        add(0, 0, 4'b1111, 4'b0000, 0, 8'h44, 4'b0000, 0);
        // owner 0 sets ptr=1; abort of owner 1 leaves ptr=1
        add(0, 1, 4'b0001, 4'b0001, 0, 8'h44, 4'b0000, 1);
        add(0, 1, 4'b0001, 4'b0001, 1, 8'h11, 4'b0001, 1);
        add(0, 1, 4'b0000, 4'b0000, 0, 8'h11, 4'b0000, 0);
        add(0, 1, 4'b0010, 4'b0010, 0, 8'h11, 4'b0000, 1);
        add(0, 1, 4'b0000, 4'b0000, 0, 8'h11, 4'b0000, 0);
        add(0, 1, 4'b1010, 4'b0010, 0, 8'h11, 4'b0000, 1);
        add(0, 1, 4'b1010, 4'b0010, 1, 8'h22, 4'b0010, 1);
        add(0, 1, 4'b0000, 4'b0000, 0, 8'h22, 4'b0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            rdy   = tbl[i].rdy;
            req   = tbl[i].req;
            tick();
            chk_all($sformatf("v%0d", i), tbl[i].g, tbl[i].ld, tbl[i].li, tbl[i].ak, tbl[i].bz);
        end

        // rdy stall in GRANT; data sampled only at the releasing edge
        reset = 1'b0;
        rdy   = 1'b1;
        req   = 4'b0010;
        tick();
        chk_all("stall_enter", 4'b0010, 0, 8'h22, 4'b0000, 1);
        for (int i = 0; i < 5; i++) begin
            rdy            = 1'b0;
            data_in[15:8]  = 8'h60 + 8'(i);
            tick();
            chk_all($sformatf("stall%0d", i), 4'b0010, 0, 8'h22, 4'b0000, 1);
        end
        data_in[15:8] = 8'h5A;
        rdy           = 1'b1;
        tick();
        chk_all("stall_load", 4'b0010, 1, 8'h5A, 4'b0010, 1);
        data_in[15:8] = 8'hFF;
        req           = 4'b0000;
        tick();
        chk_all("stall_done", 4'b0000, 0, 8'h5A, 4'b0000, 0);
        data_in = {dat[3], dat[2], dat[1], dat[0]};

        // reset during the load cycle aborts and clears ptr
        req = 4'b0100;
        tick();
        chk_all("rl_grant", 4'b0100, 0, 8'h5A, 4'b0000, 1);
        tick();
        chk_all("rl_load", 4'b0100, 1, 8'hA5, 4'b0100, 1);
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        chk_all("rl_reset", 4'b0000, 0, 8'h00, 4'b0000, 0);
        reset = 1'b0;
        req   = 4'b1010;
        tick();
        chk_all("rl_ptr0", 4'b0010, 0, 8'h00, 4'b0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
